// File: rtl/tone_decoder_if.sv
// Tone decoder signal bundle: square-wave input plus the decoded note, lock flag
// and the measured-period stream.
interface tone_decoder_if #(
  parameter int CNT_W = 18
);
  logic             tone_in;
  logic [1:0]       state;
  logic             tone_valid;
  logic [CNT_W-1:0] period;
  logic             period_stb;

  modport master (
    output tone_in,
    input  state, tone_valid, period, period_stb
  );

  modport slave (
    input  tone_in,
    output state, tone_valid, period, period_stb
  );
endinterface

// File: rtl/tone_decoder.sv
// Measures the rising-edge period of a square wave and locks onto one of four note
// codes once MATCH_CNT consecutive periods fall in the same tolerance window.
module tone_decoder #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TOL       = 2000,
  parameter int MATCH_CNT = 4,
  parameter int TIMEOUT   = 250000,
  parameter int CNT_W     = 18
) (
  input  logic           clk_50MHz,
  input  logic           rst,
  tone_decoder_if.slave  bus
);

  localparam int RUN_W = $clog2(MATCH_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MATCH_CNT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  function automatic int nominal(input int k);
    case (k)
      0:       return CLK_HZ / 261;
      1:       return CLK_HZ / 277;
      2:       return CLK_HZ / 493;
      default: return CLK_HZ / 523;
    endcase
  endfunction

  logic             s1_reg, s2_reg, s3_reg;
  logic             rise;
  logic [0:0]       fsm_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic             stb_reg;
  logic [1:0]       state_reg;
  logic             valid_reg;
  logic [1:0]       cand_reg;
  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;

  logic signed [31:0] meas;
  logic [3:0]         hit;
  logic               hit_any;
  logic [1:0]         hit_code;

  assign rise = s2_reg & ~s3_reg;
  assign meas = signed'(32'(cnt_reg));

  // One inclusive window comparator per note; the value under test is the running
  // count, which is exactly the period being latched on a rise.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      localparam int LO = nominal(gi) - TOL;
      localparam int HI = nominal(gi) + TOL;
      assign hit[gi] = (meas >= LO) && (meas <= HI);
    end
  endgenerate

  always_comb begin
    hit_any  = |hit;
    hit_code = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) hit_code = 2'(k);
    end
  end

  always_comb begin
    run_next = RUN_W'(1);
    if (hit_code == cand_reg) begin
      run_next = (run_reg >= RUN_MAX) ? RUN_MAX : run_reg + RUN_W'(1);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      s3_reg     <= 1'b0;
      fsm_reg    <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      stb_reg    <= 1'b0;
      state_reg  <= 2'd0;
      valid_reg  <= 1'b0;
      cand_reg   <= 2'd0;
      run_reg    <= '0;
    end else begin
      s1_reg  <= bus.tone_in;
      s2_reg  <= s1_reg;
      s3_reg  <= s2_reg;
      stb_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (rise) begin
            fsm_reg <= TRACK;
            cnt_reg <= CNT_W'(1);
          end
        end
        TRACK: begin
          // A rise wins over a timeout landing in the same cycle.
          if (rise) begin
            cnt_reg    <= CNT_W'(1);
            period_reg <= cnt_reg;
            stb_reg    <= 1'b1;
            if (!hit_any) begin
              run_reg   <= '0;
              valid_reg <= 1'b0;
            end else begin
              cand_reg <= hit_code;
              run_reg  <= run_next;
              if (run_next == RUN_MAX) begin
                state_reg <= hit_code;
                valid_reg <= 1'b1;
              end else if (hit_code != state_reg) begin
                valid_reg <= 1'b0;
              end
            end
          end else if (cnt_reg == TIMEOUT_C) begin
            fsm_reg   <= IDLE;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            run_reg   <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.state      = state_reg;
  assign bus.tone_valid = valid_reg;
  assign bus.period     = period_reg;
  assign bus.period_stb = stb_reg;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder at a scaled clock (CLK_HZ=50000) so note periods
// are 191/180/101/95 cycles, TOL=2, TIMEOUT=250.
module tb_tone_decoder;

  localparam int CLK_HZ  = 50_000;
  localparam int TOL     = 2;
  localparam int MATCH   = 4;
  localparam int TIMEOUT = 250;
  localparam int CNT_W   = 9;
  localparam int NV      = 38;

  typedef struct {
    int         gap;
    bit         stb;
    int         per;
    bit         valid;
    logic [1:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t tbl [NV];

  tone_decoder_if #(.CNT_W(CNT_W)) bus ();

  tone_decoder #(
    .CLK_HZ(CLK_HZ), .TOL(TOL), .MATCH_CNT(MATCH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_50MHz(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int gap, bit stb, int per, bit valid, int st);
    vec_t v;
    v.gap = gap; v.stb = stb; v.per = per; v.valid = valid; v.st = 2'(st);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  // Entered just after a posedge; raises tone_in, checks the rise's effect, and
  // returns v.gap posedges later so consecutive rises are exactly v.gap apart.
  task automatic apply(input vec_t v, input int idx);
    bus.tone_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stb", idx, int'(bus.period_stb), int'(v.stb));
    check("period", idx, int'(bus.period), v.per);
    check("valid", idx, int'(bus.tone_valid), int'(v.valid));
    check("state", idx, int'(bus.state), int'(v.st));
    @(negedge clk);
    check("stb_off", idx, int'(bus.period_stb), 0);
    bus.tone_in = 1'b0;
    repeat (v.gap - 4) @(posedge clk);
    #1;
    $display("vec %0d gap=%0d stb=%0d period=%0d valid=%0d state=%0d",
             idx, v.gap, bus.period_stb, bus.period, bus.tone_valid, bus.state);
  endtask

  initial begin
    // 261 Hz: arm, then lock on the 4th strobe
    tbl[0]  = mk(191, 0, 0,   0, 0);
    tbl[1]  = mk(191, 1, 191, 0, 0);
    tbl[2]  = mk(191, 1, 191, 0, 0);
    tbl[3]  = mk(191, 1, 191, 0, 0);
    tbl[4]  = mk(191, 1, 191, 1, 0);
    // switch to 493 Hz: drop lock at once, relock on 4th strobe
    tbl[5]  = mk(101, 1, 191, 1, 0);
    tbl[6]  = mk(101, 1, 101, 0, 0);
    tbl[7]  = mk(101, 1, 101, 0, 0);
    tbl[8]  = mk(101, 1, 101, 0, 0);
    tbl[9]  = mk(95,  1, 101, 1, 2);
    // 523 Hz
    tbl[10] = mk(95,  1, 95,  0, 2);
    tbl[11] = mk(95,  1, 95,  0, 2);
    tbl[12] = mk(95,  1, 95,  0, 2);
    tbl[13] = mk(180, 1, 95,  1, 3);
    // 277 Hz
    tbl[14] = mk(180, 1, 180, 0, 3);
    tbl[15] = mk(180, 1, 180, 0, 3);
    tbl[16] = mk(180, 1, 180, 0, 3);
    tbl[17] = mk(193, 1, 180, 1, 1);
    // P0+TOL locks
    tbl[18] = mk(193, 1, 193, 0, 1);
    tbl[19] = mk(193, 1, 193, 0, 1);
    tbl[20] = mk(193, 1, 193, 0, 1);
    tbl[21] = mk(194, 1, 193, 1, 0);
    // P0+TOL+1 misses and clears the run
    tbl[22] = mk(193, 1, 194, 0, 0);
    tbl[23] = mk(193, 1, 193, 0, 0);
    tbl[24] = mk(193, 1, 193, 0, 0);
    tbl[25] = mk(193, 1, 193, 0, 0);
    tbl[26] = mk(125, 1, 193, 1, 0);
    // 400 Hz never locks
    tbl[27] = mk(125, 1, 125, 0, 0);
    tbl[28] = mk(125, 1, 125, 0, 0);
    tbl[29] = mk(125, 1, 125, 0, 0);
    tbl[30] = mk(125, 1, 125, 0, 0);
    tbl[31] = mk(250, 1, 125, 0, 0);
    // rise exactly at cnt==TIMEOUT is measured; one cycle later it times out
    tbl[32] = mk(251, 1, 250, 0, 0);
    tbl[33] = mk(95,  0, 250, 0, 0);
    tbl[34] = mk(95,  1, 95,  0, 0);
    tbl[35] = mk(95,  1, 95,  0, 0);
    tbl[36] = mk(95,  1, 95,  0, 0);
    tbl[37] = mk(5,   1, 95,  1, 3);

    bus.tone_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 0, int'(bus.state), 0);
    check("rst_valid", 0, int'(bus.tone_valid), 0);
    check("rst_period", 0, int'(bus.period), 0);
    check("rst_stb", 0, int'(bus.period_stb), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(tbl[i], i);

    // Locked on 523 Hz, input held low: lock drops TIMEOUT cycles after the last rise
    repeat (TIMEOUT - 3) @(posedge clk);
    @(negedge clk);
    check("to_valid_before", 0, int'(bus.tone_valid), 1);
    @(posedge clk);
    @(negedge clk);
    check("to_valid_after", 0, int'(bus.tone_valid), 0);
    check("to_state", 0, int'(bus.state), 3);
    $display("timeout valid=%0d state=%0d", bus.tone_valid, bus.state);
    @(posedge clk);
    #1;
    apply(mk(95, 0, 95, 0, 3), 100);
    apply(mk(95, 1, 95, 0, 3), 101);
    apply(mk(95, 1, 95, 0, 3), 102);
    apply(mk(95, 1, 95, 0, 3), 103);
    apply(mk(10, 1, 95, 1, 3), 104);

    // One-cycle reset while locked
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 1, int'(bus.state), 0);
    check("mid_rst_valid", 1, int'(bus.tone_valid), 0);
    check("mid_rst_period", 1, int'(bus.period), 0);
    check("mid_rst_stb", 1, int'(bus.period_stb), 0);
    $display("reset state=%0d valid=%0d period=%0d", bus.state, bus.tone_valid, bus.period);
    @(posedge clk);
    #1;
    apply(mk(95, 0, 0,  0, 0), 200);
    apply(mk(95, 1, 95, 0, 0), 201);
    apply(mk(95, 1, 95, 0, 0), 202);
    apply(mk(95, 1, 95, 0, 0), 203);
    apply(mk(10, 1, 95, 1, 3), 204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
